// File: rtl/gate_exerciser.sv
// gate_exerciser: clocked, self-checking stimulus sweep for a small
// combinational gate under test.
//
// Ports:
//   clk        in   system clock, all state changes on the rising edge
//   rst        in   asynchronous active-high reset
//   start      in   begin a sweep (sampled only in IDLE or DONE)
//   dut_out    in   output of the gate under test
//   stim       out  [N_IN]   vector driven to the gate, stim[0] = LSB input
//   busy       out  high while a sweep is running
//   done       out  high from sweep completion until next start/reset
//   pass       out  valid when done: no mismatches in the last sweep
//   err_count  out  [N_IN+1] mismatching vectors in the last sweep
//   fail_valid out  at least one mismatch was recorded
//   first_fail out  [N_IN]   stim index of the first mismatch
module gate_exerciser #(
    parameter int                     N_IN   = 2,
    parameter int                     HOLD   = 2,
    parameter logic [(2**N_IN)-1:0]   EXPECT = 4'b1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            dut_out,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] first_fail
);

    // Hold counter needs at least one bit even when HOLD == 1.
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
    localparam logic [N_IN-1:0] STIM_LAST = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [HW-1:0]   hold_cnt, hold_d;
    logic [N_IN-1:0] stim_d;
    logic            busy_d;
    logic            done_d;
    logic            pass_d;
    logic [N_IN:0]   err_d;
    logic            fv_d;
    logic [N_IN-1:0] ff_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            stim       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
        end else begin
            state      <= state_d;
            hold_cnt   <= hold_d;
            stim       <= stim_d;
            busy       <= busy_d;
            done       <= done_d;
            pass       <= pass_d;
            err_count  <= err_d;
            fail_valid <= fv_d;
            first_fail <= ff_d;
        end
    end

    always_comb begin
        state_d = state;
        hold_d  = hold_cnt;
        stim_d  = stim;
        busy_d  = busy;
        done_d  = done;
        pass_d  = pass;
        err_d   = err_count;
        fv_d    = fail_valid;
        ff_d    = first_fail;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    hold_d  = '0;
                    stim_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    ff_d    = '0;
                end
            end
            RUN: begin
                if (hold_cnt != HOLD_LAST) begin
                    hold_d = hold_cnt + HW'(1);
                end else begin
                    // Sample edge: the vector has been stable HOLD cycles.
                    if (dut_out != EXPECT[stim]) begin
                        err_d = err_count + (N_IN + 1)'(1);
                        if (!fail_valid) begin
                            fv_d = 1'b1;
                            ff_d = stim;
                        end
                    end
                    if (stim == STIM_LAST) begin
                        // Verdict includes this final sample.
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        stim_d = stim + N_IN'(1);
                        hold_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gate_exerciser.sv
// tb_gate_exerciser: randomized sweeps of two gate_exerciser instances
// (defaults, and N_IN=3/HOLD=1/XOR3) against a truth-table model.
module tb_gate_exerciser;

    logic clk = 1'b0;
    logic rst;
    logic start_a, start_b;
    logic dut_out_a, dut_out_b;
    logic [3:0] gate_a;
    logic [7:0] gate_b;

    logic [1:0] stim_a;
    logic       busy_a, done_a, pass_a, fv_a;
    logic [2:0] err_a;
    logic [1:0] ff_a;

    logic [2:0] stim_b;
    logic       busy_b, done_b, pass_b, fv_b;
    logic [3:0] err_b;
    logic [2:0] ff_b;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [3:0] EXP_A = 4'b1000;
    localparam logic [7:0] EXP_B = 8'b1001_0110;

    always #5 clk = ~clk;

    // Behavioural gates under test: a plain truth-table lookup.
    assign dut_out_a = gate_a[stim_a];
    assign dut_out_b = gate_b[stim_b];

    gate_exerciser u_a (
        .clk(clk), .rst(rst), .start(start_a), .dut_out(dut_out_a),
        .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .fail_valid(fv_a), .first_fail(ff_a)
    );

    gate_exerciser #(.N_IN(3), .HOLD(1), .EXPECT(EXP_B)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .dut_out(dut_out_b),
        .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .fail_valid(fv_b), .first_fail(ff_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int n_err(input logic [7:0] tt,
                                 input logic [7:0] ex, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (tt[i] != ex[i]) c++;
        return c;
    endfunction

    function automatic int first_err(input logic [7:0] tt,
                                     input logic [7:0] ex, input int n);
        for (int i = 0; i < n; i++) if (tt[i] != ex[i]) return i;
        return 0;
    endfunction

    // Sweep on the default instance: 4 vectors x 2 cycles.
    task automatic run_a(input logic [3:0] tt, input bit keep_start);
        int e;
        gate_a  = tt;
        start_a = 1'b1;
        tick();
        if (!keep_start) start_a = 1'b0;
        for (int j = 0; j < 8; j++) begin
            check("a_stim", stim_a, j / 2);
            check("a_busy", busy_a, 1);
            check("a_done", done_a, 0);
            if (j == 0) check("a_err_clr", err_a, 0);
            tick();
        end
        start_a = 1'b0;
        e = n_err({4'b0, tt}, {4'b0, EXP_A}, 4);
        check("a_done_end", done_a, 1);
        check("a_busy_end", busy_a, 0);
        check("a_stim_end", stim_a, 3);
        check("a_err", err_a, e);
        check("a_fv", fv_a, e != 0);
        check("a_ff", ff_a, first_err({4'b0, tt}, {4'b0, EXP_A}, 4));
        check("a_pass", pass_a, e == 0);
        tick();
        check("a_hold_done", done_a, 1);
        check("a_hold_err", err_a, e);
    endtask

    // Sweep on the N_IN=3, HOLD=1 instance.
    task automatic run_b(input logic [7:0] tt);
        int e;
        gate_b  = tt;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int j = 0; j < 8; j++) begin
            check("b_stim", stim_b, j);
            check("b_busy", busy_b, 1);
            tick();
        end
        e = n_err(tt, EXP_B, 8);
        check("b_done", done_b, 1);
        check("b_stim_end", stim_b, 7);
        check("b_err", err_b, e);
        check("b_fv", fv_b, e != 0);
        check("b_ff", ff_b, first_err(tt, EXP_B, 8));
        check("b_pass", pass_b, e == 0);
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        gate_a = 4'b1000;
        gate_b = EXP_B;
        #2;
        check("rst_stim", stim_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_pass", pass_a, 0);
        check("rst_err", err_a, 0);
        tick();
        rst = 1'b0;
        tick();

        run_a(4'b1000, 1'b0);
        run_a(4'b1110, 1'b0);
        run_a(4'b0000, 1'b0);
        run_a(4'b1000, 1'b1);
        run_a(4'b0110, 1'b0);
        for (int k = 0; k < 6; k++)
            run_a(4'($urandom), 1'($urandom));

        // Async reset mid-sweep, between edges.
        gate_a  = 4'b0000;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        check("arst_stim", stim_a, 0);
        check("arst_busy", busy_a, 0);
        check("arst_done", done_a, 0);
        check("arst_pass", pass_a, 0);
        check("arst_err", err_a, 0);
        check("arst_fv", fv_a, 0);
        check("arst_ff", ff_a, 0);
        tick();
        rst = 1'b0;
        tick();
        check("arst_idle", busy_a, 0);
        run_a(4'b1000, 1'b0);

        run_b(EXP_B);
        run_b(8'b0000_0000);
        for (int k = 0; k < 5; k++) run_b(8'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
